sprite_engine: RTL and testbench

Parametrised multi-sprite icon renderer for the VGA path. Up to N_SPRITES rojobot tanks are drawn as square icons, rotated by each bot's orientation. Each sprite has its own hit → burst → respawn state machine, and the engine drives one shared tank ROM and one shared burst ROM. It sits between the dtg/IO_BotInfo sources and the colorizer, and replaces the per-tank single-sprite icon logic. Its outputs are a transparency flag and a 12-bit RGB code, pipeline-aligned to the incoming pixel coordinates.

---
 rtl/sprite_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_sprite_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// sprite_engine: multi-sprite icon renderer for the VGA path.
// Draws up to N_SPRITES rotated square tank icons. Each channel runs its own
// hit -> burst -> respawn sequence. One shared address drives both the tank
// ROM and the burst ROM. The outputs are aligned 3 clocks behind the pixel
// coordinates.
// Ports:
//   clock, reset (async, active-low)
//   pixel_column, pixel_row  : current display coordinates
//   LocX_reg, LocY_reg       : packed 8-bit bot positions, channel i at [8i+7:8i]
//   BotInfo_reg              : packed bot info, [2:0] = orientation
//   hit                      : per-channel hit strobe
//   body_color               : per-channel RGB for palette index 2
//   rom_addr                 : shared ROM address (ROMs have a 1-clock read)
//   tank_data, boom_data     : ROM read data
//   icon, icon_c, icon_id    : draw flag, colour and owning channel
//   burst, bot_reset         : per-channel burst state and respawn pulse
module sprite_engine #(
  parameter int          N_SPRITES      = 2,
  parameter int          ICON_BITS      = 5,
  parameter int          X_SHIFT        = 3,
  parameter int          Y_SCALE        = 6,
  parameter int          BURST_CYCLES   = 32'h3000000,
  parameter int          RESPAWN_CYCLES = 17,
  parameter logic [11:0] TRANSPARENT    = 12'hFFF,
  localparam int         ID_W           = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  localparam int         ADDR_W         = 2 * ICON_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [11:0]              pixel_column,
  input  logic [11:0]              pixel_row,
  input  logic [8*N_SPRITES-1:0]   LocX_reg,
  input  logic [8*N_SPRITES-1:0]   LocY_reg,
  input  logic [8*N_SPRITES-1:0]   BotInfo_reg,
  input  logic [N_SPRITES-1:0]     hit,
  input  logic [12*N_SPRITES-1:0]  body_color,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [1:0]               tank_data,
  input  logic [11:0]              boom_data,
  output logic                     icon,
  output logic [11:0]              icon_c,
  output logic [ID_W-1:0]          icon_id,
  output logic [N_SPRITES-1:0]     burst,
  output logic [N_SPRITES-1:0]     bot_reset
);

  localparam logic [12:0]          ICON_SPAN = 13'((1 << ICON_BITS) - 1);
  localparam logic [ICON_BITS-1:0] ICON_M    = {ICON_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_BURST   = 2'd1,
    ST_RESPAWN = 2'd2
  } state_t;

  // 13-bit coordinates keep right/bottom windows from wrapping to 0
  logic [12:0] pc_s, pr_s;
  assign pc_s = {1'b0, pixel_column};
  assign pr_s = {1'b0, pixel_row};

  // Only the orientation bits [2:1] are used; bit 0 and the upper bits are ignored
  logic [8*N_SPRITES-1:0] unused_botinfo_s;
  assign unused_botinfo_s = BotInfo_reg;

  logic [N_SPRITES-1:0] win_s;
  logic [ADDR_W-1:0]    addr_ch_s [N_SPRITES];
  logic [11:0]          body_s    [N_SPRITES];

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_ch
    logic [12:0]          col_s, row_s;
    logic [ICON_BITS-1:0] dc_s, dr_s;
    logic [1:0]           orient_s;
    logic [ADDR_W-1:0]    addr_s;
    state_t               state_r;
    logic [31:0]          cnt_r;
    logic                 burst_r, respawn_r;

    assign col_s    = 13'(LocX_reg[8*g +: 8]) << X_SHIFT;
    assign row_s    = 13'(LocY_reg[8*g +: 8]) * 13'(Y_SCALE);
    assign dc_s     = ICON_BITS'(pc_s - col_s);
    assign dr_s     = ICON_BITS'(pr_s - row_s);
    // Diagonal orientations fold down to the next lower cardinal
    assign orient_s = BotInfo_reg[8*g+1 +: 2];
    assign body_s[g] = body_color[12*g +: 12];
    assign win_s[g] = (pc_s >= col_s) && (pc_s <= col_s + ICON_SPAN) &&
                      (pr_s >= row_s) && (pr_s <= row_s + ICON_SPAN);

    // Rotate the icon by remapping row/column offsets into the ROM address
    always_comb begin
      case (orient_s)
        2'd0:    addr_s = {dr_s, dc_s};                    // North
        2'd1:    addr_s = {ICON_M - dc_s, dr_s};           // East
        2'd2:    addr_s = {ICON_M - dr_s, ICON_M - dc_s};  // South
        2'd3:    addr_s = {dc_s, ICON_M - dr_s};           // West
        default: addr_s = {dr_s, dc_s};
      endcase
    end
    assign addr_ch_s[g] = addr_s;

    // Per-channel hit -> burst -> respawn sequencer with registered status outputs
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_r   <= ST_ALIVE;
        cnt_r     <= 32'd0;
        burst_r   <= 1'b0;
        respawn_r <= 1'b0;
      end else begin
        case (state_r)
          ST_ALIVE: begin
            cnt_r     <= 32'd0;
            respawn_r <= 1'b0;
            if (hit[g]) begin
              state_r <= ST_BURST;
              burst_r <= 1'b1;
            end else begin
              burst_r <= 1'b0;
            end
          end
          ST_BURST: begin
            if (cnt_r == 32'(BURST_CYCLES - 1)) begin
              state_r   <= ST_RESPAWN;
              cnt_r     <= 32'd0;
              burst_r   <= 1'b0;
              respawn_r <= 1'b1;
            end else begin
              cnt_r     <= cnt_r + 32'd1;
              burst_r   <= 1'b1;
              respawn_r <= 1'b0;
            end
          end
          ST_RESPAWN: begin
            burst_r <= 1'b0;
            if (cnt_r == 32'(RESPAWN_CYCLES - 1)) begin
              state_r   <= ST_ALIVE;
              cnt_r     <= 32'd0;
              respawn_r <= 1'b0;
            end else begin
              cnt_r     <= cnt_r + 32'd1;
              respawn_r <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_ALIVE;
            cnt_r     <= 32'd0;
            burst_r   <= 1'b0;
            respawn_r <= 1'b0;
          end
        endcase
      end
    end

    assign burst[g]     = burst_r;
    assign bot_reset[g] = respawn_r;
  end

  logic              sel_hit_s, sel_burst_s;
  logic [ID_W-1:0]   sel_id_s;
  logic [ADDR_W-1:0] sel_addr_s;

  // Priority select: scan high to low so the lowest-index hit wins
  always_comb begin
    sel_hit_s   = 1'b0;
    sel_burst_s = 1'b0;
    sel_id_s    = {ID_W{1'b0}};
    sel_addr_s  = {ADDR_W{1'b0}};
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (win_s[i]) begin
        sel_hit_s   = 1'b1;
        sel_burst_s = burst[i];
        sel_id_s    = ID_W'(i);
        sel_addr_s  = addr_ch_s[i];
      end else begin
        // no window here: keep the candidate already chosen
      end
    end
  end

  logic            valid_r1, valid_r2, bsel_r1, bsel_r2;
  logic [ID_W-1:0] id_r1, id_r2;

  // Stage 1 (address) and stage 2 (ROM latency) pipeline registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rom_addr <= {ADDR_W{1'b0}};
      valid_r1 <= 1'b0;
      bsel_r1  <= 1'b0;
      id_r1    <= {ID_W{1'b0}};
      valid_r2 <= 1'b0;
      bsel_r2  <= 1'b0;
      id_r2    <= {ID_W{1'b0}};
    end else begin
      rom_addr <= sel_addr_s;
      valid_r1 <= sel_hit_s;
      bsel_r1  <= sel_burst_s;
      id_r1    <= sel_id_s;
      valid_r2 <= valid_r1;
      bsel_r2  <= bsel_r1;
      id_r2    <= id_r1;
    end
  end

  logic [11:0] color_s;

  // Colour source: burst ROM while bursting, otherwise the tank palette
  always_comb begin
    if (bsel_r2) begin
      color_s = boom_data;
    end else begin
      case (tank_data)
        2'd0:    color_s = 12'hFFF;
        2'd1:    color_s = 12'h000;
        2'd2:    color_s = body_s[id_r2];
        2'd3:    color_s = 12'h025;
        default: color_s = 12'hFFF;
      endcase
    end
  end

  // Stage 3: register outputs; colour and id hold while nothing is drawn
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      icon    <= 1'b0;
      icon_c  <= 12'h000;
      icon_id <= {ID_W{1'b0}};
    end else if (valid_r2 && (color_s != TRANSPARENT)) begin
      icon    <= 1'b1;
      icon_c  <= color_s;
      icon_id <= id_r2;
    end else begin
      icon    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed testbench for sprite_engine with two channels and short burst and
// respawn times. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point.
module tb_sprite_engine;

  logic        clock;
  logic        reset;
  logic [11:0] pixel_column, pixel_row;
  logic [15:0] LocX_reg, LocY_reg, BotInfo_reg;
  logic [1:0]  hit;
  logic [23:0] body_color;
  logic [9:0]  rom_addr;
  logic [1:0]  tank_data;
  logic [11:0] boom_data;
  logic        icon;
  logic [11:0] icon_c;
  logic [0:0]  icon_id;
  logic [1:0]  burst, bot_reset;

  int total = 0;
  int bad   = 0;

  sprite_engine #(
    .N_SPRITES(2), .ICON_BITS(5), .X_SHIFT(3), .Y_SCALE(6),
    .BURST_CYCLES(20), .RESPAWN_CYCLES(3), .TRANSPARENT(12'hFFF)
  ) dut (
    .clock(clock), .reset(reset),
    .pixel_column(pixel_column), .pixel_row(pixel_row),
    .LocX_reg(LocX_reg), .LocY_reg(LocY_reg), .BotInfo_reg(BotInfo_reg),
    .hit(hit), .body_color(body_color),
    .rom_addr(rom_addr), .tank_data(tank_data), .boom_data(boom_data),
    .icon(icon), .icon_c(icon_c), .icon_id(icon_id),
    .burst(burst), .bot_reset(bot_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int c, input int r);
    pixel_column = 12'(c);
    pixel_row    = 12'(r);
  endtask

  initial begin
    reset        = 1'b0;
    hit          = 2'b00;
    pix(0, 0);
    LocX_reg     = {8'd100, 8'd10};
    LocY_reg     = {8'd100, 8'd10};
    BotInfo_reg  = 16'h0000;
    body_color   = {12'h123, 12'h0A5};
    tank_data    = 2'd2;
    boom_data    = 12'hF80;
    repeat (3) tick();
    chk("rst_icon", 32'(icon), 32'd0);
    chk("rst_icon_c", 32'(icon_c), 32'h000);
    chk("rst_icon_id", 32'(icon_id), 32'd0);
    chk("rst_burst", 32'(burst), 32'd0);
    chk("rst_bot_reset", 32'(bot_reset), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    reset = 1'b1;
    repeat (3) tick();
    chk("idle_icon", 32'(icon), 32'd0);

    // North, first pixel of the window: 3-clock latency
    pix(80, 60);
    tick();
    chk("north_addr", 32'(rom_addr), 32'h000);
    chk("lat1_icon", 32'(icon), 32'd0);
    tick();
    chk("lat2_icon", 32'(icon), 32'd0);
    tick();
    chk("lat3_icon", 32'(icon), 32'd1);
    chk("lat3_icon_c", 32'(icon_c), 32'h0A5);
    chk("lat3_icon_id", 32'(icon_id), 32'd0);

    // Orientation remapping at offset dr=2, dc=1
    pix(81, 62);
    BotInfo_reg = 16'h0002; tick(); chk("east_addr", 32'(rom_addr), 32'h3C2);
    BotInfo_reg = 16'h0004; tick(); chk("south_addr", 32'(rom_addr), 32'h3BE);
    BotInfo_reg = 16'h0006; tick(); chk("west_addr", 32'(rom_addr), 32'h03D);
    BotInfo_reg = 16'h0003; tick(); chk("diag3_addr", 32'(rom_addr), 32'h3C2);
    BotInfo_reg = 16'h0001; tick(); chk("diag1_addr", 32'(rom_addr), 32'h041);
    BotInfo_reg = 16'h0007; tick(); chk("diag7_addr", 32'(rom_addr), 32'h03D);
    BotInfo_reg = 16'h0000;

    // Bot1 alone, then transparent (colour and id must hold)
    LocX_reg = {8'd20, 8'd10}; LocY_reg = {8'd20, 8'd10};
    pix(160, 120); tank_data = 2'd2;
    repeat (3) tick();
    chk("bot1_icon", 32'(icon), 32'd1);
    chk("bot1_icon_id", 32'(icon_id), 32'd1);
    chk("bot1_icon_c", 32'(icon_c), 32'h123);
    tank_data = 2'd0;
    repeat (3) tick();
    chk("transp_icon", 32'(icon), 32'd0);
    chk("hold_icon_c", 32'(icon_c), 32'h123);
    chk("hold_icon_id", 32'(icon_id), 32'd1);

    // Overlap: channel 0 wins
    LocX_reg = {8'd10, 8'd10}; LocY_reg = {8'd10, 8'd10};
    pix(80, 60); tank_data = 2'd1;
    repeat (3) tick();
    chk("ovl_icon", 32'(icon), 32'd1);
    chk("ovl_icon_id", 32'(icon_id), 32'd0);
    chk("ovl_icon_c", 32'(icon_c), 32'h000);
    tank_data = 2'd0;
    repeat (3) tick();
    chk("ovl_transp_icon", 32'(icon), 32'd0);

    // Right-edge clipping: bot0 at column 1016
    LocX_reg = {8'd0, 8'd127}; LocY_reg = {8'd100, 8'd10};
    tank_data = 2'd2;
    pix(1023, 60);
    tick(); chk("edge_addr", 32'(rom_addr), 32'h007);
    repeat (2) tick();
    chk("edge_1023_icon", 32'(icon), 32'd1);
    chk("edge_1023_icon_c", 32'(icon_c), 32'h0A5);
    pix(0, 60);    repeat (3) tick(); chk("edge_col0_icon", 32'(icon), 32'd0);
    pix(1015, 60); repeat (3) tick(); chk("edge_1015_icon", 32'(icon), 32'd0);
    pix(1016, 60); repeat (3) tick(); chk("edge_1016_icon", 32'(icon), 32'd1);
    pix(1047, 60); repeat (3) tick(); chk("edge_1047_icon", 32'(icon), 32'd1);
    pix(1048, 60); repeat (3) tick(); chk("edge_1048_icon", 32'(icon), 32'd0);
    pix(1020, 91); repeat (3) tick(); chk("edge_row91_icon", 32'(icon), 32'd1);
    pix(1020, 92); repeat (3) tick(); chk("edge_row92_icon", 32'(icon), 32'd0);

    // Burst on channel 1 with a transparent tank and an opaque burst colour
    LocX_reg = {8'd20, 8'd127}; LocY_reg = {8'd20, 8'd10};
    pix(160, 120); tank_data = 2'd0; boom_data = 12'hF80;
    repeat (3) tick();
    chk("preburst_icon", 32'(icon), 32'd0);
    hit = 2'b10;
    tick();
    hit = 2'b00;
    for (int k = 0; k < 20; k++) begin
      chk("burst_hi", 32'(burst), 32'b10);
      chk("burst_no_rst", 32'(bot_reset), 32'b00);
      if (k == 10) begin
        chk("burst_icon", 32'(icon), 32'd1);
        chk("burst_icon_c", 32'(icon_c), 32'hF80);
        chk("burst_icon_id", 32'(icon_id), 32'd1);
      end
      hit = (k == 4) ? 2'b10 : 2'b00;
      tick();
    end
    hit = 2'b00;
    for (int k = 0; k < 3; k++) begin
      chk("respawn_burst_lo", 32'(burst), 32'b00);
      chk("respawn_hi", 32'(bot_reset), 32'b10);
      tick();
    end
    chk("alive_bot_reset", 32'(bot_reset), 32'b00);
    chk("alive_burst", 32'(burst), 32'b00);
    repeat (3) tick();
    chk("alive_icon", 32'(icon), 32'd0);

    // Reset 5 clocks into a burst on channel 0
    hit = 2'b01;
    tick();
    hit = 2'b00;
    repeat (5) tick();
    chk("midburst_burst", 32'(burst), 32'b01);
    #2 reset = 1'b0;
    #1;
    chk("async_burst", 32'(burst), 32'b00);
    chk("async_bot_reset", 32'(bot_reset), 32'b00);
    chk("async_icon", 32'(icon), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("post_rst_bot_reset", 32'(bot_reset), 32'b00);
      chk("post_rst_burst", 32'(burst), 32'b00);
    end

    // hit in the same clock as reset release is honoured on the next edge
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hit   = 2'b01;
    tick();
    hit   = 2'b00;
    chk("release_hit_burst", 32'(burst), 32'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
